// File: rtl/mlp_pkg.sv
// mlp_pkg: shared definitions for the sequential MLP core.
//   - register addresses and CTRL bit positions
//   - sequencer state encoding
//   - sat_act(): clamps a wide signed sum into an OUT-width range
//     (ReLU floor at 0 or signed floor at -2^(w-1)); sums up to 64 bits.
package mlp_pkg;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_INPUT  = 3'd1;
  localparam logic [2:0] A_WEIGHT = 3'd2;
  localparam logic [2:0] A_OUTPUT = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;

  localparam int B_RUN     = 0;
  localparam int B_DONE    = 1;
  localparam int B_IRQ_EN  = 2;
  localparam int B_LAYER   = 3;
  localparam int B_BUSY    = 4;
  localparam int B_PTR_CLR = 5;
  localparam int B_ERR     = 6;

  typedef enum logic [2:0] {
    S_IDLE, S_H_BIAS, S_H_MAC, S_H_ACT, S_O_BIAS, S_O_MAC, S_O_ACT
  } state_t;

  function automatic logic signed [63:0] sat_act(input logic signed [63:0] v,
                                                 input int w, input logic relu);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = relu ? 64'sd0 : -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/mlp_mac_act.sv
// mlp_mac_act: shared accumulator + activation for both MLP layers.
//   clk, rst      clock, async active-low reset
//   load          acc <= sign-extended w (bias cycle)
//   mac_en        acc <= acc + a*w
//   lin           1: linear signed saturation, 0: ReLU + positive saturation
//   a, w          signed operand / weight (w doubles as the bias)
//   act           activation of (acc >>> FRAC_BITS), combinational
// MAC_WIDTH must not exceed 64 (the saturation helper works on 64 bits).
module mlp_mac_act
  import mlp_pkg::*;
#(
  parameter int A_W       = 16,
  parameter int WGT_WIDTH = 16,
  parameter int MAC_WIDTH = 64,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        mac_en,
  input  logic                        lin,
  input  logic signed [A_W-1:0]       a,
  input  logic signed [WGT_WIDTH-1:0] w,
  output logic signed [OUT_WIDTH-1:0] act
);

  logic signed [A_W+WGT_WIDTH-1:0] prod;
  logic signed [MAC_WIDTH-1:0]     acc, sum;
  logic signed [63:0]              sat;
  logic                            unused_sat;

  assign prod = a * w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        acc <= '0;
    else if (load)   acc <= MAC_WIDTH'(w);
    else if (mac_en) acc <= acc + MAC_WIDTH'(prod);
  end

  assign sum        = acc >>> FRAC_BITS;
  assign sat        = sat_act(64'(sum), OUT_WIDTH, !lin);
  assign act        = sat[OUT_WIDTH-1:0];
  assign unused_sat = ^sat;

endmodule

// File: rtl/mlp_seq_core.sv
// mlp_seq_core: time-multiplexed two-layer MLP behind a small register bus.
//   clk, rst            clock, async active-low reset
//   write_en/read_en    bus strobes; addr selects CTRL/INPUT/WEIGHT/OUTPUT/STATUS
//   writedata/readdata  32-bit bus data; readdata registered, held between reads
//   irq                 DONE & IRQ_EN
// Build option: MLP_SEQ_OUT_RELU_EN makes the output layer ReLU like the
// hidden layer; otherwise the output layer is linear with signed saturation.
module mlp_seq_core
  import mlp_pkg::*;
#(
  parameter int N_INPUTS  = 2,
  parameter int N_HIDDEN  = 4,
  parameter int N_OUTPUT  = 2,
  parameter int IN_WIDTH  = 16,
  parameter int WGT_WIDTH = 16,
  parameter int MAC_WIDTH = 64,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [2:0]  addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int HW_N = N_HIDDEN * (N_INPUTS + 1);
  localparam int OW_N = N_OUTPUT * (N_HIDDEN + 1);
  localparam int IW   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int HIW  = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
  localparam int OIW  = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;
  localparam int HWW  = $clog2(HW_N);
  localparam int OWW  = $clog2(OW_N);
  localparam int WAW  = (HWW > OWW) ? HWW : OWW;
  localparam int CW   = (IW > HIW) ? IW : HIW;
  localparam int NW   = (HIW > OIW) ? HIW : OIW;
  localparam int A_W  = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;

  state_t state;
  logic   done, err, irq_en, layer_sel;
  logic [IW-1:0]  in_ptr;
  logic [HWW-1:0] hw_ptr;
  logic [OWW-1:0] ow_ptr;
  logic [OIW-1:0] out_ptr;
  logic [WAW-1:0] wa;   // walks the active layer's weight memory linearly
  logic [CW-1:0]  k;    // MAC operand index
  logic [NW-1:0]  n;    // neuron index

  logic signed [IN_WIDTH-1:0]  x_mem  [N_INPUTS];
  logic signed [WGT_WIDTH-1:0] hw_mem [HW_N];
  logic signed [WGT_WIDTH-1:0] ow_mem [OW_N];
  logic signed [OUT_WIDTH-1:0] hid    [N_HIDDEN];
  logic signed [OUT_WIDTH-1:0] res    [N_OUTPUT];

  logic busy, out_layer, lin, unused_wd;
  logic signed [WGT_WIDTH-1:0] w_cur;
  logic signed [A_W-1:0]       a_cur;
  logic signed [OUT_WIDTH-1:0] act;
  logic [31:0] ctrl_rd, status_rd;

  assign busy      = (state != S_IDLE);
  assign out_layer = state inside {S_O_BIAS, S_O_MAC, S_O_ACT};
  assign w_cur     = out_layer ? ow_mem[wa[OWW-1:0]] : hw_mem[wa[HWW-1:0]];
  assign a_cur     = out_layer ? A_W'(hid[k[HIW-1:0]]) : A_W'(x_mem[k[IW-1:0]]);
  assign irq       = done & irq_en;
  assign ctrl_rd   = {25'd0, err, 1'b0, busy, layer_sel, irq_en, done, 1'b0};
  assign status_rd = {8'(out_ptr), 8'(ow_ptr), 8'(hw_ptr), 8'(in_ptr)};
  assign unused_wd = ^writedata;

`ifdef MLP_SEQ_OUT_RELU_EN
  assign lin = 1'b0;
`else
  assign lin = out_layer;
`endif

  mlp_mac_act #(
    .A_W(A_W), .WGT_WIDTH(WGT_WIDTH), .MAC_WIDTH(MAC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH), .FRAC_BITS(FRAC_BITS)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .load   (state == S_H_BIAS || state == S_O_BIAS),
    .mac_en (state == S_H_MAC  || state == S_O_MAC),
    .lin    (lin),
    .a      (a_cur),
    .w      (w_cur),
    .act    (act)
  );

  // Statement order matters: W1C clears precede sets so a set in the same
  // cycle wins, and a RUN in the same cycle as an OUTPUT read zeroes out_ptr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      {done, err, irq_en, layer_sel} <= '0;
      in_ptr <= '0; hw_ptr <= '0; ow_ptr <= '0; out_ptr <= '0;
      wa <= '0; k <= '0; n <= '0;
      readdata <= '0;
      for (int i = 0; i < N_INPUTS; i++) x_mem[i]  <= '0;
      for (int i = 0; i < HW_N; i++)     hw_mem[i] <= '0;
      for (int i = 0; i < OW_N; i++)     ow_mem[i] <= '0;
      for (int i = 0; i < N_HIDDEN; i++) hid[i]    <= '0;
      for (int i = 0; i < N_OUTPUT; i++) res[i]    <= '0;
    end else begin
      if (read_en) begin
        case (addr)
          A_CTRL:   readdata <= ctrl_rd;
          A_STATUS: readdata <= status_rd;
          A_OUTPUT: begin
            readdata <= 32'(res[out_ptr]);
            out_ptr  <= (out_ptr == OIW'(N_OUTPUT - 1)) ? '0 : out_ptr + 1'b1;
          end
          default:  readdata <= '0;
        endcase
      end

      if (write_en) begin
        case (addr)
          A_CTRL: begin
            irq_en    <= writedata[B_IRQ_EN];
            layer_sel <= writedata[B_LAYER];
            if (writedata[B_DONE]) done <= 1'b0;
            if (writedata[B_ERR])  err  <= 1'b0;
            if (writedata[B_PTR_CLR]) begin
              in_ptr <= '0; hw_ptr <= '0; ow_ptr <= '0; out_ptr <= '0;
            end
            if (writedata[B_RUN]) begin
              if (busy) err <= 1'b1;
              else begin
                state <= S_H_BIAS;
                done <= 1'b0; out_ptr <= '0;
                wa <= '0; k <= '0; n <= '0;
              end
            end
          end
          A_INPUT: begin
            if (busy) err <= 1'b1;
            else begin
              x_mem[in_ptr] <= writedata[IN_WIDTH-1:0];
              in_ptr <= (in_ptr == IW'(N_INPUTS - 1)) ? '0 : in_ptr + 1'b1;
            end
          end
          A_WEIGHT: begin
            if (busy) err <= 1'b1;
            else if (layer_sel) begin
              ow_mem[ow_ptr] <= writedata[WGT_WIDTH-1:0];
              ow_ptr <= (ow_ptr == OWW'(OW_N - 1)) ? '0 : ow_ptr + 1'b1;
            end else begin
              hw_mem[hw_ptr] <= writedata[WGT_WIDTH-1:0];
              hw_ptr <= (hw_ptr == HWW'(HW_N - 1)) ? '0 : hw_ptr + 1'b1;
            end
          end
          default: ;
        endcase
      end

      case (state)
        S_IDLE: ;
        S_H_BIAS: begin wa <= wa + 1'b1; k <= '0; state <= S_H_MAC; end
        S_H_MAC: begin
          wa <= wa + 1'b1; k <= k + 1'b1;
          if (k == CW'(N_INPUTS - 1)) state <= S_H_ACT;
        end
        S_H_ACT: begin
          hid[n[HIW-1:0]] <= act;
          if (n == NW'(N_HIDDEN - 1)) begin
            n <= '0; wa <= '0; state <= S_O_BIAS;
          end else begin
            n <= n + 1'b1; state <= S_H_BIAS;
          end
        end
        S_O_BIAS: begin wa <= wa + 1'b1; k <= '0; state <= S_O_MAC; end
        S_O_MAC: begin
          wa <= wa + 1'b1; k <= k + 1'b1;
          if (k == CW'(N_HIDDEN - 1)) state <= S_O_ACT;
        end
        S_O_ACT: begin
          res[n[OIW-1:0]] <= act;
          if (n == NW'(N_OUTPUT - 1)) begin
            n <= '0; state <= S_IDLE; done <= 1'b1;
          end else begin
            n <= n + 1'b1; state <= S_O_BIAS;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mlp_seq_core.md
# mlp_seq_core

Parametrised, time-multiplexed two-layer MLP accelerator with a memory-mapped register interface. It succeeds the fixed single-output MLP: it supports any number of output neurons, fixed-point scaling, auto-incrementing output readback and error flagging. A single shared MAC computes hidden and output layers in sequence. It sits on the processor bus as a slave and raises `irq` on completion.

## Interface
- `N_INPUTS`, 2: input vector length.
- `N_HIDDEN`, 4: hidden neurons.
- `N_OUTPUT`, 2: output neurons (≥1).
- `IN_WIDTH`, 16: signed input width.
- `WGT_WIDTH`, 16: signed weight/bias width.
- `MAC_WIDTH`, 64: signed accumulator width.
- `OUT_WIDTH`, 16: signed activation/output width.
- `FRAC_BITS`, 0: arithmetic right shift applied to each sum before activation.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `write_en`  in  1  register write strobe.
- `read_en`  in  1  register read strobe.
- `addr`  in  3  register address.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `irq`  out  1  level interrupt, equal to DONE & IRQ_EN.

## Operation
- Register map:
  - 0 CTRL. Bit0 RUN: write-1 starts, self-clearing. Bit1 DONE: sticky, write-1-clears. Bit2 IRQ_EN. Bit3 LAYER_SEL (0 hidden, 1 output). Bit4 BUSY (read-only). Bit5 PTR_CLR: write-1 zeroes all pointers, self-clearing. Bit6 ERR: sticky, write-1-clears.
  - 1 INPUT: write stores `writedata[IN_WIDTH-1:0]` at the input pointer, then increments it; wraps N_INPUTS-1→0.
  - 2 WEIGHT: write stores into the layer given by LAYER_SEL at that layer's pointer, then increments it.
    - Hidden order: per neuron, bias then N_INPUTS weights. Wraps at N_HIDDEN*(N_INPUTS+1).
    - Output order: per neuron, bias then N_HIDDEN weights. Wraps at N_OUTPUT*(N_HIDDEN+1).
  - 3 OUTPUT: read returns `result[out_ptr]`, sign-extended to 32 bits. `read_en` increments `out_ptr`, wrapping at N_OUTPUT.
  - 4 STATUS: [7:0] input pointer, [15:8] hidden weight pointer, [23:16] output weight pointer, [31:24] `out_ptr`.
  - 5–7: read 0; writes ignored.
- A CTRL write updates IRQ_EN and LAYER_SEL, and DONE/ERR per the W1C rules.
- FSM states and transitions:
  - IDLE→H_BIAS on RUN. Starting clears DONE and `out_ptr`.
  - H_BIAS: load bias into accumulator.
  - H_MAC: N_INPUTS cycles, one product per cycle.
  - H_ACT: writes hidden activation, then goes to H_BIAS for the next neuron, or to O_BIAS after the last.
  - O_BIAS / O_MAC (N_HIDDEN cycles) / O_ACT: same pattern over the output neurons, using hidden activations as inputs.
  - After the last O_ACT: →IDLE and set DONE.
- Arithmetic:
  - Product is IN_WIDTH+WGT_WIDTH bits (hidden activations are OUT_WIDTH), sign-extended into a MAC_WIDTH accumulator; no accumulator saturation.
  - Sum is shifted right arithmetically by FRAC_BITS, then activated.
  - Hidden activation: <0→0; >2^(OUT_WIDTH-1)-1→that maximum; otherwise truncated to OUT_WIDTH bits.
- Boundary conditions:
  - Writes to INPUT or WEIGHT while BUSY: ignored, set ERR.
  - RUN while BUSY: ignored, sets ERR.
  - CTRL write of DONE-clear in the same cycle DONE is set: set wins.
  - Reset at any time: abort, FSM→IDLE, all registers, memories, pointers and results→0.

## Timing
- Reset values: `readdata`=0, `irq`=0, all CTRL bits 0.
- `readdata`: valid the cycle after `addr`/`read_en` are sampled. The auto-increment takes effect for the next read.
- Latency: the RUN write is sampled at edge E0 and BUSY=1 from E0. DONE and `irq` rise at E0+L, where L = N_HIDDEN*(N_INPUTS+2) + N_OUTPUT*(N_HIDDEN+2). Defaults give L=28.
- BUSY falls on the same edge that DONE rises.

## Configuration
- `MLP_SEQ_OUT_RELU_EN` defined: output layer uses ReLU plus positive saturation, identical to the hidden layer.
- Undefined: output layer is linear with signed saturation to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. The hidden layer always uses ReLU.

## Structure
- Shared package `mlp_pkg`:
  - register address constants;
  - CTRL bit positions;
  - FSM state enum;
  - saturation helper function.
- One sub-module, `mlp_mac_act`: accumulator with bias load, MAC enable, shift and activation, plus the output-mode select.

## Test plan
- Defaults, x=[7,-3], every hidden neuron bias 0 with w=[2,1], every output neuron bias 5 with w=1 → each hidden neuron=11, results 49,49; DONE at E0+28; `irq`=1 only with IRQ_EN set.
- Inputs 32767,32767 with hidden w=32767 → hidden saturates to 32767. Output bias -100, w=0 → result 0 with the macro defined, -100 without it.
- Write 3 INPUT values (1,2,3) with N_INPUTS=2 → STATUS input pointer reads 1; input[0]=3.
- During BUSY, a WEIGHT write and a second RUN → both ignored, ERR=1, result unchanged; W1C clears ERR.
- FRAC_BITS=8, x=[256,256], w=[256,256], bias 0 → hidden=512.
- Three consecutive OUTPUT reads with N_OUTPUT=2 → result0, result1, result0. Reset asserted mid-H_MAC → BUSY=0, `readdata`=0, and a new RUN computes correctly.
